// File: rtl/vga_scan_driver.sv
// VGA raster timing generator: issues pixel coordinates, captures the colour
// returned for them and drives sync/RGB pins aligned with that captured colour.
module vga_scan_driver #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_POL   = 0,
    parameter int CLK_DIV    = 2,
    parameter int PIPE_TICKS = 1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [7:0]  RGB_in,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic        pixelTick,
    output logic        activeVideo,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam logic SYNC_ON = (SYNC_POL != 0);

    logic [DIV_W-1:0] div_q, div_d;
    logic [10:0]      hcount_q, hcount_d;
    logic [10:0]      vcount_q, vcount_d;
    logic             sof_q, sof_d;
    logic             tick, h_wrap, v_wrap;
    logic             active_raw, hs_raw, vs_raw;

    logic [PIPE_TICKS-1:0] act_dly_q, act_dly_d;
    logic [PIPE_TICKS-1:0] hs_dly_q, hs_dly_d;
    logic [PIPE_TICKS-1:0] vs_dly_q, vs_dly_d;
    logic [7:0]            rgb_dly_q [PIPE_TICKS];
    logic [7:0]            rgb_dly_d [PIPE_TICKS];
    logic [7:0]            rgb_out;

    assign tick   = (div_q == DIV_W'(CLK_DIV - 1));
    assign h_wrap = (hcount_q == 11'(H_TOTAL - 1));
    assign v_wrap = (vcount_q == 11'(V_TOTAL - 1));

    assign active_raw = (hcount_q < 11'(H_ACTIVE)) && (vcount_q < 11'(V_ACTIVE));
    assign hs_raw     = (hcount_q >= 11'(H_ACTIVE + H_FP)) &&
                        (hcount_q <  11'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_raw     = (vcount_q >= 11'(V_ACTIVE + V_FP)) &&
                        (vcount_q <  11'(V_ACTIVE + V_FP + V_SYNC));

    always_comb begin
        div_d    = tick ? '0 : div_q + DIV_W'(1);
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        // h-wrap and v-wrap resolve on the same tick at the end of a frame
        if (tick) begin
            if (h_wrap) begin
                hcount_d = '0;
                vcount_d = v_wrap ? '0 : vcount_q + 11'd1;
            end else begin
                hcount_d = hcount_q + 11'd1;
            end
        end
        sof_d = tick && h_wrap && v_wrap;
    end

    always_comb begin
        act_dly_d = act_dly_q;
        hs_dly_d  = hs_dly_q;
        vs_dly_d  = vs_dly_q;
        rgb_dly_d = rgb_dly_q;
        // RGB_in sampled on the tick edge belongs to the pixel being retired
        if (tick) begin
            act_dly_d[0] = active_raw;
            hs_dly_d[0]  = hs_raw;
            vs_dly_d[0]  = vs_raw;
            rgb_dly_d[0] = RGB_in;
            for (int i = 1; i < PIPE_TICKS; i++) begin
                act_dly_d[i] = act_dly_q[i-1];
                hs_dly_d[i]  = hs_dly_q[i-1];
                vs_dly_d[i]  = vs_dly_q[i-1];
                rgb_dly_d[i] = rgb_dly_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            div_q     <= '0;
            hcount_q  <= '0;
            vcount_q  <= '0;
            sof_q     <= 1'b0;
            act_dly_q <= '0;
            hs_dly_q  <= '0;
            vs_dly_q  <= '0;
        end else begin
            div_q     <= div_d;
            hcount_q  <= hcount_d;
            vcount_q  <= vcount_d;
            sof_q     <= sof_d;
            act_dly_q <= act_dly_d;
            hs_dly_q  <= hs_dly_d;
            vs_dly_q  <= vs_dly_d;
        end
    end

    // Colour data is hard-blanked by the delayed active flag, so it needs no reset
    always_ff @(posedge clk) begin
        rgb_dly_q <= rgb_dly_d;
    end

    assign rgb_out      = rgb_dly_q[PIPE_TICKS-1];
    assign pixelX       = hcount_q;
    assign pixelY       = vcount_q;
    assign startOfFrame = sof_q;
    assign pixelTick    = tick;
    assign activeVideo  = act_dly_q[PIPE_TICKS-1];
    assign vga_hs       = hs_dly_q[PIPE_TICKS-1] ? SYNC_ON : ~SYNC_ON;
    assign vga_vs       = vs_dly_q[PIPE_TICKS-1] ? SYNC_ON : ~SYNC_ON;
    assign vga_r        = activeVideo ? {rgb_out[7:5], rgb_out[7]} : 4'd0;
    assign vga_g        = activeVideo ? {rgb_out[4:2], rgb_out[4]} : 4'd0;
    assign vga_b        = activeVideo ? {rgb_out[1:0], rgb_out[1:0]} : 4'd0;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Directed bench for vga_scan_driver: a full-size instance for line timing and
// colour expansion, plus a tiny-raster instance for frame, vsync and reset checks.
module tb_vga_scan_driver;

    logic        clk;
    logic        resetN;
    logic [7:0]  rgb_in;
    logic [10:0] pixel_x, pixel_y;
    logic        sof, tick, active, hs, vs;
    logic [3:0]  r, g, b;

    logic [7:0]  rgb_in_s;
    logic [10:0] pixel_x_s, pixel_y_s;
    logic        sof_s, tick_s, active_s, hs_s, vs_s;
    logic [3:0]  r_s, g_s, b_s;

    int checks = 0;
    int errors = 0;

    vga_scan_driver dut (
        .clk(clk), .resetN(resetN), .RGB_in(rgb_in),
        .pixelX(pixel_x), .pixelY(pixel_y), .startOfFrame(sof),
        .pixelTick(tick), .activeVideo(active),
        .vga_hs(hs), .vga_vs(vs), .vga_r(r), .vga_g(g), .vga_b(b)
    );

    // 15 x 8 raster, 2 clk per pixel: 240 clk per frame
    vga_scan_driver #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(0), .CLK_DIV(2), .PIPE_TICKS(1)
    ) dut_s (
        .clk(clk), .resetN(resetN), .RGB_in(rgb_in_s),
        .pixelX(pixel_x_s), .pixelY(pixel_y_s), .startOfFrame(sof_s),
        .pixelTick(tick_s), .activeVideo(active_s),
        .vga_hs(hs_s), .vga_vs(vs_s), .vga_r(r_s), .vga_g(g_s), .vga_b(b_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] actual,
                            input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_pix(input int x, input int y, input int limit);
        int n = 0;
        while (!(pixel_x == 11'(x) && pixel_y == 11'(y)) && n < limit) begin
            step(1);
            n++;
        end
        check_eq("wait_pix_x", 32'(pixel_x), 32'(x));
        check_eq("wait_pix_y", 32'(pixel_y), 32'(y));
    endtask

    task automatic wait_pix_s(input int x, input int y, input int limit);
        int n = 0;
        while (!(pixel_x_s == 11'(x) && pixel_y_s == 11'(y)) && n < limit) begin
            step(1);
            n++;
        end
        check_eq("wait_pix_s_x", 32'(pixel_x_s), 32'(x));
        check_eq("wait_pix_s_y", 32'(pixel_y_s), 32'(y));
    endtask

    initial begin
        int n;
        resetN   = 1'b0;
        rgb_in   = 8'h00;
        rgb_in_s = 8'hFF;
        step(5);
        check_eq("rst_x", 32'(pixel_x), 0);
        check_eq("rst_y", 32'(pixel_y), 0);
        check_eq("rst_hs", 32'(hs), 1);
        check_eq("rst_vs", 32'(vs), 1);
        check_eq("rst_rgb", 32'({r, g, b}), 0);
        check_eq("rst_sof", 32'(sof), 0);
        check_eq("rst_tick", 32'(tick), 0);
        check_eq("rst_active", 32'(active), 0);

        resetN = 1'b1;
        rgb_in = 8'hFF;
        step(1);
        check_eq("first_tick", 32'(tick), 1);
        check_eq("first_tick_x", 32'(pixel_x), 0);
        step(1);
        check_eq("after_tick", 32'(tick), 0);
        check_eq("after_tick_x", 32'(pixel_x), 1);
        check_eq("pix0_active", 32'(active), 1);
        check_eq("pix0_r", 32'(r), 4'hF);
        check_eq("no_sof_exit", 32'(sof), 0);

        // Horizontal active edge: pixel 639 still shown, 640 blanked
        wait_pix(640, 0, 4000);
        check_eq("h639_active", 32'(active), 1);
        check_eq("h639_rgb", 32'({r, g, b}), 12'hFFF);
        step(2);
        check_eq("h640_active", 32'(active), 0);
        check_eq("h640_rgb", 32'({r, g, b}), 0);

        // hsync falls one tick after hcount reaches 656
        wait_pix(656, 0, 4000);
        check_eq("hs_before", 32'(hs), 1);
        step(2);
        check_eq("hs_fall", 32'(hs), 0);
        n = 0;
        while (hs == 1'b0 && n < 4000) begin
            step(1);
            n++;
        end
        check_eq("hs_low_clk", 32'(n), 192);
        n = 0;
        while (hs == 1'b1 && n < 4000) begin
            step(1);
            n++;
        end
        check_eq("hs_high_clk", 32'(n), 1408);

        // Colour expansion
        wait_pix(10, 10, 20000);
        rgb_in = 8'hE0;
        step(2);
        check_eq("e0_r", 32'(r), 4'hF);
        check_eq("e0_g", 32'(g), 4'h0);
        check_eq("e0_b", 32'(b), 4'h0);
        check_eq("e0_vs", 32'(vs), 1);
        rgb_in = 8'b0110_1110;
        step(2);
        check_eq("6e_r", 32'(r), 4'h6);
        check_eq("6e_g", 32'(g), 4'h6);
        check_eq("6e_b", 32'(b), 4'hA);
        rgb_in = 8'hFF;

        // Small raster: frame period and pulse shape
        n = 0;
        while (sof_s == 1'b0 && n < 600) begin
            step(1);
            n++;
        end
        check_eq("sof_x", 32'(pixel_x_s), 0);
        check_eq("sof_y", 32'(pixel_y_s), 0);
        step(1);
        check_eq("sof_width", 32'(sof_s), 0);
        n = 1;
        while (sof_s == 1'b0 && n < 600) begin
            step(1);
            n++;
        end
        check_eq("sof_period", 32'(n), 240);

        // Vertical active edge
        wait_pix_s(1, 3, 600);
        check_eq("v3_active", 32'(active_s), 1);
        check_eq("v3_r", 32'(r_s), 4'hF);
        wait_pix_s(1, 4, 600);
        check_eq("v4_active", 32'(active_s), 0);
        check_eq("v4_rgb", 32'({r_s, g_s, b_s}), 0);

        // vsync covers delayed lines 5..6 only
        wait_pix_s(0, 5, 600);
        check_eq("vs_before", 32'(vs_s), 1);
        step(2);
        check_eq("vs_fall", 32'(vs_s), 0);
        n = 0;
        while (vs_s == 1'b0 && n < 600) begin
            step(1);
            n++;
        end
        check_eq("vs_low_clk", 32'(n), 60);

        // Mid-sync reset abandons both pulses
        wait_pix_s(11, 6, 600);
        check_eq("s_hs_low", 32'(hs_s), 0);
        check_eq("s_vs_low", 32'(vs_s), 0);
        step(2);
        resetN = 1'b0;
        step(1);
        check_eq("mid_rst_x", 32'(pixel_x_s), 0);
        check_eq("mid_rst_y", 32'(pixel_y_s), 0);
        check_eq("mid_rst_hs", 32'(hs_s), 1);
        check_eq("mid_rst_vs", 32'(vs_s), 1);
        check_eq("mid_rst_active", 32'(active_s), 0);
        check_eq("mid_rst_sof", 32'(sof_s), 0);
        check_eq("mid_rst_big_x", 32'(pixel_x), 0);
        resetN = 1'b1;
        n = 0;
        while (sof_s == 1'b0 && n < 600) begin
            step(1);
            n++;
        end
        check_eq("rst_to_sof", 32'(n), 240);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
